// File: rtl/pcs_tx_lpi_ctrl.sv
// EEE low-power-idle TX sequencer between the RS and the 64b/66b encoder.
// Substitutes LPI/Idle blocks on all lanes and drives the PMA transmit disable.
module pcs_tx_lpi_ctrl #(
    parameter int LANES          = 2,
    parameter int SLEEP_CYCLES   = 4,
    parameter int QUIET_CYCLES   = 64,
    parameter int REFRESH_CYCLES = 8,
    parameter int WAKE_CYCLES    = 16,
    parameter int CNT_W          = 16
) (
    input  logic                  TX_CLK,
    input  logic                  TX_RST,
    input  logic                  LPI_REQ,
    input  logic [64*LANES-1:0]   TXD_IN,
    input  logic [8*LANES-1:0]    TX_C_IN,
    output logic [64*LANES-1:0]   TXD_OUT,
    output logic [8*LANES-1:0]    TX_C_OUT,
    output logic                  TX_QUIET,
    output logic                  TX_READY,
    output logic [2:0]            LPI_STATE,
    output logic [15:0]           LPI_COUNT
);

    typedef enum logic [2:0] {
        ACTIVE  = 3'd0,
        SLEEP   = 3'd1,
        QUIET   = 3'd2,
        REFRESH = 3'd3,
        WAKE    = 3'd4
    } state_t;

    localparam logic [64*LANES-1:0] LPI_TXD  = {(8*LANES){8'h06}};
    localparam logic [64*LANES-1:0] IDLE_TXD = {(8*LANES){8'h07}};
    localparam logic [8*LANES-1:0]  CTL_ALL  = {(8*LANES){1'b1}};

    localparam logic [CNT_W-1:0] T_SLEEP   = CNT_W'(SLEEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_QUIET   = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_REFRESH = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_WAKE    = CNT_W'(WAKE_CYCLES - 1);

    state_t           st;
    state_t           nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             expired;
    logic             entry;
    logic             illegal;

    assign expired   = (timer == '0);
    assign LPI_STATE = st;

    always_comb begin
        nxt       = st;
        timer_nxt = expired ? timer : timer - 1'b1;
        entry     = 1'b0;
        illegal   = 1'b0;
        case (st)
            ACTIVE: begin
                if (LPI_REQ) begin
                    nxt       = SLEEP;
                    timer_nxt = T_SLEEP;
                    entry     = 1'b1;
                end
            end
            SLEEP: begin
                if (expired) begin
                    nxt       = LPI_REQ ? QUIET : WAKE;
                    timer_nxt = LPI_REQ ? T_QUIET : T_WAKE;
                end
            end
            QUIET: begin
                // a wake request beats the refresh timer
                if (!LPI_REQ) begin
                    nxt       = WAKE;
                    timer_nxt = T_WAKE;
                end else if (expired) begin
                    nxt       = REFRESH;
                    timer_nxt = T_REFRESH;
                end
            end
            REFRESH: begin
                if (!LPI_REQ) begin
                    nxt       = WAKE;
                    timer_nxt = T_WAKE;
                end else if (expired) begin
                    nxt       = QUIET;
                    timer_nxt = T_QUIET;
                end
            end
            WAKE: begin
                if (expired) begin
                    nxt       = ACTIVE;
                    timer_nxt = '0;
                end
            end
            default: begin
                nxt       = ACTIVE;
                timer_nxt = '0;
                illegal   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge TX_CLK) begin
        if (TX_RST) begin
            st        <= ACTIVE;
            timer     <= '0;
            LPI_COUNT <= '0;
            TXD_OUT   <= IDLE_TXD;
            TX_C_OUT  <= CTL_ALL;
            TX_QUIET  <= 1'b0;
            TX_READY  <= 1'b0;
        end else begin
            st       <= nxt;
            timer    <= timer_nxt;
            TX_QUIET <= (nxt == QUIET);
            TX_READY <= (nxt == ACTIVE) && !illegal;
            if (entry && LPI_COUNT != 16'hFFFF)
                LPI_COUNT <= LPI_COUNT + 16'd1;
            case (nxt)
                ACTIVE: begin
                    // recovering from a bad encoding shows Idle, not RS data
                    TXD_OUT  <= illegal ? IDLE_TXD : TXD_IN;
                    TX_C_OUT <= illegal ? CTL_ALL : TX_C_IN;
                end
                SLEEP, QUIET, REFRESH: begin
                    TXD_OUT  <= LPI_TXD;
                    TX_C_OUT <= CTL_ALL;
                end
                default: begin
                    TXD_OUT  <= IDLE_TXD;
                    TX_C_OUT <= CTL_ALL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcs_tx_lpi_ctrl.sv
// Directed table-driven bench for pcs_tx_lpi_ctrl.
// Short timer settings keep every LPI phase visible in a few dozen cycles.
module tb_pcs_tx_lpi_ctrl;

    localparam logic [127:0] LPI_TXD  = {16{8'h06}};
    localparam logic [127:0] IDLE_TXD = {16{8'h07}};
    localparam logic [1:0]   K_PASS   = 2'd0;
    localparam logic [1:0]   K_LPI    = 2'd1;
    localparam logic [1:0]   K_IDLE   = 2'd2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [127:0] txd_in;
    logic [15:0]  txc_in;
    logic [127:0] txd_out;
    logic [15:0]  txc_out;
    logic         quiet;
    logic         ready;
    logic [2:0]   state;
    logic [15:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic         req;
        logic [127:0] txd;
        logic [15:0]  txc;
        logic [2:0]   st;
        logic [1:0]   kind;
        logic         quiet;
        logic [15:0]  cnt;
    } vec_t;

    vec_t v [64];
    int   nv = 0;

    pcs_tx_lpi_ctrl #(
        .LANES(2), .SLEEP_CYCLES(4), .QUIET_CYCLES(10),
        .REFRESH_CYCLES(3), .WAKE_CYCLES(5), .CNT_W(16)
    ) dut (
        .TX_CLK(clk), .TX_RST(rst), .LPI_REQ(req),
        .TXD_IN(txd_in), .TX_C_IN(txc_in),
        .TXD_OUT(txd_out), .TX_C_OUT(txc_out),
        .TX_QUIET(quiet), .TX_READY(ready),
        .LPI_STATE(state), .LPI_COUNT(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] s,
                       input logic [1:0] k, input logic q,
                       input logic [15:0] c);
        v[nv].req   = r;
        v[nv].txd   = {4{32'(nv * 32'h0101_0101)}}
                      ^ 128'h0123456789ABCDEF_FEDCBA9876543210;
        v[nv].txc   = 16'(nv * 37);
        v[nv].st    = s;
        v[nv].kind  = k;
        v[nv].quiet = q;
        v[nv].cnt   = c;
        nv++;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".state"}, 128'(state), 128'd0);
        chk({tag, ".txd"}, txd_out, IDLE_TXD);
        chk({tag, ".txc"}, 128'(txc_out), 128'hFFFF);
        chk({tag, ".quiet"}, 128'(quiet), 128'd0);
        chk({tag, ".ready"}, 128'(ready), 128'd0);
        chk({tag, ".count"}, 128'(count), 128'd0);
    endtask

    initial begin
        logic [127:0] etxd;
        logic [15:0]  etxc;
        bit           hit;

        // pass-through, full sleep/quiet/refresh, early wake
        add(0, 0, K_PASS, 0, 0);
        add(0, 0, K_PASS, 0, 0);
        for (int i = 0; i < 4; i++)  add(1, 1, K_LPI, 0, 1);
        for (int i = 0; i < 10; i++) add(1, 2, K_LPI, 1, 1);
        for (int i = 0; i < 3; i++)  add(1, 3, K_LPI, 0, 1);
        for (int i = 0; i < 3; i++)  add(1, 2, K_LPI, 1, 1);
        for (int i = 0; i < 5; i++)  add(0, 4, K_IDLE, 0, 1);
        add(0, 0, K_PASS, 0, 1);
        add(0, 0, K_PASS, 0, 1);
        // one-cycle request: full sleep then wake, never quiet
        add(1, 1, K_LPI, 0, 2);
        for (int i = 0; i < 3; i++)  add(0, 1, K_LPI, 0, 2);
        for (int i = 0; i < 5; i++)  add(0, 4, K_IDLE, 0, 2);
        add(0, 0, K_PASS, 0, 2);
        // request held through wake: one ACTIVE cycle, then sleep again
        add(1, 1, K_LPI, 0, 3);
        for (int i = 0; i < 3; i++)  add(0, 1, K_LPI, 0, 3);
        add(0, 4, K_IDLE, 0, 3);
        for (int i = 0; i < 4; i++)  add(1, 4, K_IDLE, 0, 3);
        add(1, 0, K_PASS, 0, 3);
        add(1, 1, K_LPI, 0, 4);

        rst    = 1'b1;
        req    = 1'b0;
        txd_in = '0;
        txc_in = '0;
        repeat (2) @(posedge clk);
        #1 chk_idle("reset");

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < nv; i++) begin
            req    = v[i].req;
            txd_in = v[i].txd;
            txc_in = v[i].txc;
            @(posedge clk);
            #1;
            etxd = (v[i].kind == K_PASS) ? v[i].txd :
                   (v[i].kind == K_LPI)  ? LPI_TXD : IDLE_TXD;
            etxc = (v[i].kind == K_PASS) ? v[i].txc : 16'hFFFF;
            chk($sformatf("row%0d.state", i), 128'(state), 128'(v[i].st));
            chk($sformatf("row%0d.txd", i), txd_out, etxd);
            chk($sformatf("row%0d.txc", i), 128'(txc_out), 128'(etxc));
            chk($sformatf("row%0d.quiet", i), 128'(quiet), 128'(v[i].quiet));
            chk($sformatf("row%0d.ready", i), 128'(ready),
                128'(v[i].kind == K_PASS));
            chk($sformatf("row%0d.count", i), 128'(count), 128'(v[i].cnt));
            @(negedge clk);
        end

        // reset while quiet
        req = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            #1 hit = (state == 3'd2);
        end
        chk("reach_quiet", 128'(hit), 128'd1);
        @(posedge clk);
        #1 chk("quiet_on", 128'(quiet), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_idle("rst_quiet");
        @(negedge clk);
        rst    = 1'b0;
        req    = 1'b0;
        txd_in = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        txc_in = 16'h0F01;
        @(posedge clk);
        #1;
        chk("post_rst.txd", txd_out, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
        chk("post_rst.txc", 128'(txc_out), 128'h0F01);
        chk("post_rst.ready", 128'(ready), 128'd1);

        // counter saturation via preload
        @(negedge clk);
        force dut.LPI_COUNT = 16'hFFFE;
        #1 release dut.LPI_COUNT;
        req = 1'b1;
        @(posedge clk);
        #1;
        chk("sat1.count", 128'(count), 128'hFFFF);
        chk("sat1.state", 128'(state), 128'd1);
        @(negedge clk);
        req = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("sat.back_active", 128'(state), 128'd0);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        chk("sat2.count", 128'(count), 128'hFFFF);
        chk("sat2.state", 128'(state), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
